// File: rtl/regfile_pkg.sv
// Shared constants and the bitwise masked-merge helper for the register file
// and other datapath blocks.
package regfile_pkg;

  localparam int RF_N = 32;
  localparam int RF_M = 3;
  localparam int RF_R = 3;
  localparam int RF_W = 2;

  // One bit of a masked write: mask=1 takes the new bit, mask=0 keeps the old one.
  function automatic logic rf_merge_bit(input logic cur, input logic mask, input logic val);
    return (cur & ~mask) | (val & mask);
  endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Read/write/reserve bus of the multi-port register file.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int N = RF_N,
  parameter int M = RF_M,
  parameter int R = RF_R,
  parameter int W = RF_W
);
  logic [R*M-1:0]  r;
  logic [R*N-1:0]  v;
  logic [R-1:0]    rbusy;
  logic [W-1:0]    we;
  logic [W*M-1:0]  wid;
  logic [W*N-1:0]  wmask;
  logic [W*N-1:0]  wval;
  logic            resv;
  logic [M-1:0]    resv_id;
  logic [2**M-1:0] busy;

  modport master (
    output r, we, wid, wmask, wval, resv, resv_id,
    input  v, rbusy, busy
  );

  modport slave (
    input  r, we, wid, wmask, wval, resv, resv_id,
    output v, rbusy, busy
  );
endinterface

// File: rtl/regfile_merge.sv
// Combinational next value of one register: applies every matching write port
// in ascending port order, so higher ports win on overlapping mask bits.
module regfile_merge
  import regfile_pkg::*;
#(
  parameter int N = RF_N,
  parameter int M = RF_M,
  parameter int W = RF_W
) (
  input  logic [N-1:0]   cur,
  input  logic [M-1:0]   idx,
  input  logic [W-1:0]   we,
  input  logic [W*M-1:0] wid,
  input  logic [W*N-1:0] wmask,
  input  logic [W*N-1:0] wval,
  output logic [N-1:0]   nxt,
  output logic           written
);

  always_comb begin
    nxt     = cur;
    written = 1'b0;
    for (int p = 0; p < W; p++) begin
      if (we[p] && (wid[p*M +: M] == idx)) begin
        written = 1'b1;
        for (int b = 0; b < N; b++) begin
          nxt[b] = rf_merge_bit(nxt[b], wmask[p*N + b], wval[p*N + b]);
        end
      end
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file with masked write merge, optional write-to-read
// bypass and a per-register busy scoreboard. Register 0 reads as zero.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int N      = RF_N,
  parameter int M      = RF_M,
  parameter int R      = RF_R,
  parameter int W      = RF_W,
  parameter int BYPASS = 1
) (
  input  logic          clk,
  input  logic          rst,
  regfile_mp_if.slave   bus
);

  localparam int NR = 2**M;

  logic [N-1:0]  regs [NR];
  logic [N-1:0]  nxt  [NR];
  logic [NR-1:0] wr;
  logic [NR-1:0] busy_q;

  assign nxt[0] = '0;
  assign wr[0]  = 1'b0;

  // The same merge results feed both the commit and the bypass read path.
  for (genvar i = 1; i < NR; i++) begin : g_merge
    regfile_merge #(.N(N), .M(M), .W(W)) u_merge (
      .cur     (regs[i]),
      .idx     (M'(i)),
      .we      (bus.we),
      .wid     (bus.wid),
      .wmask   (bus.wmask),
      .wval    (bus.wval),
      .nxt     (nxt[i]),
      .written (wr[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NR; i++) begin
        regs[i] <= '0;
      end
      busy_q <= '0;
    end else begin
      regs[0]   <= '0;
      busy_q[0] <= 1'b0;
      // A new reservation supersedes a producer completing in the same cycle.
      for (int i = 1; i < NR; i++) begin
        regs[i] <= nxt[i];
        if (bus.resv && (bus.resv_id == M'(i))) begin
          busy_q[i] <= 1'b1;
        end else if (wr[i]) begin
          busy_q[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.busy = busy_q;

  // rbusy always comes from registered state, never from the bypass path.
  always_comb begin
    logic [M-1:0] id;
    id        = '0;
    bus.v     = '0;
    bus.rbusy = '0;
    for (int k = 0; k < R; k++) begin
      id = bus.r[k*M +: M];
      if (id != '0) begin
        bus.v[k*N +: N] = ((BYPASS != 0) && !rst) ? nxt[id] : regs[id];
        bus.rbusy[k]    = busy_q[id];
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: a bypassing and a non-bypassing instance share stimulus
// and are checked against an array-based model of the register file.
module tb_regfile_mp;

  localparam int N  = 32;
  localparam int M  = 3;
  localparam int R  = 3;
  localparam int W  = 2;
  localparam int NR = 8;

  logic clk;
  logic rst;
  int   nchk;
  int   nfail;

  logic [N-1:0]  mdl [NR];
  logic [NR-1:0] mbusy;

  regfile_mp_if #(.N(N), .M(M), .R(R), .W(W)) bus1 ();
  regfile_mp_if #(.N(N), .M(M), .R(R), .W(W)) bus0 ();

  assign bus0.r       = bus1.r;
  assign bus0.we      = bus1.we;
  assign bus0.wid     = bus1.wid;
  assign bus0.wmask   = bus1.wmask;
  assign bus0.wval    = bus1.wval;
  assign bus0.resv    = bus1.resv;
  assign bus0.resv_id = bus1.resv_id;

  regfile_mp #(.N(N), .M(M), .R(R), .W(W), .BYPASS(1)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  regfile_mp #(.N(N), .M(M), .R(R), .W(W), .BYPASS(0)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
    nchk++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s observed %h expected %h", tag, got, exp);
    end
  endtask

  // Value register i would hold after this edge, following the merge rule literally.
  function automatic logic [N-1:0] mnext(input int i);
    logic [N-1:0] cur;
    logic [N-1:0] mk;
    cur = mdl[i];
    for (int p = 0; p < W; p++) begin
      if (bus1.we[p] && (int'(bus1.wid[p*M +: M]) == i)) begin
        mk  = bus1.wmask[p*N +: N];
        cur = (cur & ~mk) | (bus1.wval[p*N +: N] & mk);
      end
    end
    return cur;
  endfunction

  function automatic logic mwritten(input int i);
    for (int p = 0; p < W; p++) begin
      if (bus1.we[p] && (int'(bus1.wid[p*M +: M]) == i)) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic idle();
    rst          = 1'b0;
    bus1.we      = '0;
    bus1.wid     = '0;
    bus1.wmask   = '0;
    bus1.wval    = '0;
    bus1.resv    = 1'b0;
    bus1.resv_id = '0;
  endtask

  task automatic wr(input int p, input int id, input logic [N-1:0] mask, input logic [N-1:0] val);
    bus1.we[p]          = 1'b1;
    bus1.wid[p*M +: M]  = M'(id);
    bus1.wmask[p*N +: N] = mask;
    bus1.wval[p*N +: N]  = val;
  endtask

  task automatic rd(input int k, input int id);
    bus1.r[k*M +: M] = M'(id);
  endtask

  // Check every output against the model mid-cycle, then advance model and DUT one edge.
  task automatic step();
    logic [N-1:0]  nv [NR];
    logic [NR-1:0] nb;
    int id;
    @(negedge clk);
    for (int k = 0; k < R; k++) begin
      id = int'(bus1.r[k*M +: M]);
      chk($sformatf("v_byp[%0d]", k), bus1.v[k*N +: N],
          (id == 0) ? '0 : (rst ? mdl[id] : mnext(id)));
      chk($sformatf("v_nobyp[%0d]", k), bus0.v[k*N +: N], (id == 0) ? '0 : mdl[id]);
      chk($sformatf("rbusy[%0d]", k), N'(bus1.rbusy[k]), N'(mbusy[id]));
      chk($sformatf("rbusy0[%0d]", k), N'(bus0.rbusy[k]), N'(mbusy[id]));
    end
    chk("busy", N'(bus1.busy), N'(mbusy));
    chk("busy0", N'(bus0.busy), N'(mbusy));
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < NR; i++) nv[i] = '0;
      nb = '0;
    end else begin
      nv[0] = '0;
      nb    = mbusy;
      nb[0] = 1'b0;
      for (int i = 1; i < NR; i++) begin
        nv[i] = mnext(i);
        if (bus1.resv && (int'(bus1.resv_id) == i)) nb[i] = 1'b1;
        else if (mwritten(i)) nb[i] = 1'b0;
      end
    end
    for (int i = 0; i < NR; i++) mdl[i] = nv[i];
    mbusy = nb;
    #1;
  endtask

  initial begin
    nchk  = 0;
    nfail = 0;
    for (int i = 0; i < NR; i++) mdl[i] = '0;
    mbusy  = '0;
    bus1.r = '0;
    idle();
    rst = 1'b1;
    @(posedge clk);
    for (int i = 0; i < NR; i++) mdl[i] = '0;
    #1;

    // Reset clears a previously written register.
    idle();
    wr(0, 5, 32'hFFFF_FFFF, 32'hDEAD_BEEF);
    rd(0, 5);
    step();
    idle();
    rst = 1'b1;
    step();
    idle();
    rd(0, 5); rd(1, 5); rd(2, 5);
    #1;
    chk("reset_v0", bus1.v[0 +: N], 32'h0);
    chk("reset_v0_nobyp", bus0.v[0 +: N], 32'h0);
    chk("reset_busy", N'(bus1.busy), 32'h0);
    step();

    // Masked merge: port 1 wins on overlap, non-overlapping port 0 bits land.
    wr(0, 3, 32'hFFFF_FFFF, 32'h1122_3344);
    step();
    idle();
    wr(0, 3, 32'h0000_FFFF, 32'hAAAA_AAAA);
    wr(1, 3, 32'h00FF_FF00, 32'hBBBB_BBBB);
    step();
    idle();
    rd(0, 3);
    #1;
    chk("merge_order", bus1.v[0 +: N], 32'h11BB_BBAA);
    chk("merge_order_nobyp", bus0.v[0 +: N], 32'h11BB_BBAA);
    step();

    // Bypass instance sees the write this cycle; the other sees it next cycle.
    wr(0, 2, 32'hFFFF_FFFF, 32'h1234_5678);
    rd(0, 2);
    #1;
    chk("bypass_same_cycle", bus1.v[0 +: N], 32'h1234_5678);
    chk("nobypass_old", bus0.v[0 +: N], 32'h0);
    step();
    idle();
    #1;
    chk("nobypass_next", bus0.v[0 +: N], 32'h1234_5678);
    step();

    // Register 0 ignores writes and reservations.
    wr(0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    bus1.resv = 1'b1; bus1.resv_id = 3'd0;
    rd(0, 0);
    #1;
    chk("r0_byp", bus1.v[0 +: N], 32'h0);
    step();
    idle();
    #1;
    chk("r0_busy", N'(bus1.busy[0]), 32'h0);
    chk("r0_read", bus1.v[0 +: N], 32'h0);
    step();

    // Scoreboard: reserve, mask-0 write clears, reserve+write keeps busy.
    wr(0, 4, 32'hFFFF_FFFF, 32'hCAFE_0004);
    step();
    idle();
    bus1.resv = 1'b1; bus1.resv_id = 3'd4;
    step();
    idle();
    rd(1, 4);
    #1;
    chk("resv_busy4", N'(bus1.busy[4]), 32'h1);
    chk("resv_rbusy", N'(bus1.rbusy[1]), 32'h1);
    wr(0, 4, 32'h0, 32'hFFFF_FFFF);
    step();
    idle();
    #1;
    chk("mask0_busy4", N'(bus1.busy[4]), 32'h0);
    chk("mask0_data", bus1.v[N +: N], 32'hCAFE_0004);
    bus1.resv = 1'b1; bus1.resv_id = 3'd6;
    wr(0, 6, 32'hFFFF_FFFF, 32'h0000_0066);
    step();
    idle();
    rd(2, 6);
    #1;
    chk("resv_wr_busy6", N'(bus1.busy[6]), 32'h1);
    chk("resv_wr_data6", bus1.v[2*N +: N], 32'h0000_0066);
    step();

    // Reset beats a simultaneous write and reserve.
    wr(0, 1, 32'hFFFF_FFFF, 32'h0000_0077);
    step();
    idle();
    wr(0, 1, 32'hFFFF_FFFF, 32'h0000_0055);
    bus1.resv = 1'b1; bus1.resv_id = 3'd1;
    rst = 1'b1;
    rd(0, 1);
    #1;
    chk("rst_read_stored", bus1.v[0 +: N], 32'h0000_0077);
    step();
    idle();
    rd(0, 1);
    #1;
    chk("rst_mid_data", bus1.v[0 +: N], 32'h0);
    chk("rst_mid_busy", N'(bus1.busy[1]), 32'h0);
    step();

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      idle();
      rst = ($urandom_range(0, 39) == 0);
      for (int p = 0; p < W; p++) begin
        if ($urandom_range(0, 1) == 1) begin
          case ($urandom_range(0, 3))
            0:       wr(p, int'($urandom_range(0, NR-1)), 32'hFFFF_FFFF, $urandom);
            1:       wr(p, int'($urandom_range(0, NR-1)), 32'h0, $urandom);
            default: wr(p, int'($urandom_range(0, NR-1)), $urandom, $urandom);
          endcase
        end
      end
      bus1.resv    = ($urandom_range(0, 2) == 0);
      bus1.resv_id = M'($urandom_range(0, NR-1));
      for (int k = 0; k < R; k++) rd(k, int'($urandom_range(0, NR-1)));
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
